vec_beat_seq: RTL and testbench
===============================

# vec_beat_seq

Vector beat sequencer: the consumer of the configuration state (`avl`, `sew`) that the vset configuration logic produces. On each accepted vector operation it captures the active vector length and element width. It then issues the operation as a stream of `DATA_WIDTH`-bit beats, each with a byte-enable mask and a first-element index, to the lane datapath over a valid/ready handshake. It signals completion with a one-cycle done pulse.

## Interface
Parameters:
- `VLEN`, 16384: vector register length in bits.
- `DATA_WIDTH`, 64: beat width in bits; a power of two, minimum 64.
- `VLMAX`, `VLEN >> 3`: maximum element count.
- `VLEN_B_BITS`, `$clog2(VLMAX)`: element-index width.
- `ENABLE_64_BIT`, 1: when 0, `sew` = 3 is illegal.
- Derived, not overridable: `BPB = DATA_WIDTH/8` bytes per beat; `BB = $clog2(BPB)`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  request to begin an operation.
- `start_ready`  out  1  high only in IDLE.
- `avl`  in  VLEN_B_BITS+1  element count, 0..VLMAX; sampled on the start handshake.
- `sew`  in  2  element width, 0 = 8b, 1 = 16b, 2 = 32b, 3 = 64b; sampled on the start handshake.
- `abort`  in  1  cancels the operation in flight.
- `beat_valid`  out  1  beat presented.
- `beat_ready`  in  1  datapath accepts the beat.
- `beat_idx`  out  VLEN_B_BITS+4  beat number, starting at 0.
- `beat_be`  out  BPB  byte enables.
- `beat_elem`  out  VLEN_B_BITS+1  index of the first element carried by the beat.
- `beat_last`  out  1  final beat of the operation.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  qualifies `done`; set for an illegal `sew`.

## Operation
- States: IDLE, RUN, FIN.
- IDLE:
  - `start_ready` = 1.
  - Handshake is `start & start_ready`. On it the block latches `sew`, computes `nbytes = avl << sew` (width VLEN_B_BITS+4, no truncation) and clears the beat counter.
  - If `avl` = 0, or `sew` = 3 with `ENABLE_64_BIT` = 0, the next state is FIN. `err` = 1 for the illegal-`sew` case only. No beats are issued.
  - Otherwise the next state is RUN.
- Beat count: `nbeats = ceil(nbytes / BPB)`, i.e. `(nbytes + BPB-1) >> BB`.
- RUN:
  - `beat_valid` = 1.
  - A beat transfers on `beat_valid & beat_ready`; `beat_idx` then increments.
  - `beat_last = (beat_idx == nbeats-1)`.
  - `beat_elem = beat_idx * (BPB >> sew)`, computed as a shift by `BB - sew`.
  - `beat_be` is all ones, except on the last beat when `rem = nbytes mod BPB` is nonzero; then `beat_be = (1 << rem) - 1`.
  - The transfer of the last beat moves the state to FIN.
  - While `beat_valid` is high and `beat_ready` is low, all beat outputs hold stable.
- FIN:
  - `done` = 1 for exactly one cycle; `err` is valid in the same cycle.
  - Next state is IDLE.
- abort:
  - In RUN, `abort` takes priority over a same-cycle beat handshake. That beat does not count. Next state is IDLE with no `done`.
  - In IDLE and FIN, `abort` is ignored.
- `start` outside IDLE is ignored; it is not queued.

## Timing
- Reset, synchronous (`rst_n` = 0 at a rising edge): state IDLE, `start_ready` = 1, `beat_valid` = 0, `beat_idx` = 0, `beat_elem` = 0, `beat_be` = 0, `beat_last` = 0, `done` = 0, `err` = 0. Reset mid-RUN drops the operation with no `done`.
- Start handshake at edge N: `beat_valid` = 1 from cycle N+1.
- One beat per cycle while `beat_ready` is held high; `nbeats` beats take `nbeats` cycles.
- Last-beat handshake at edge M: `done` = 1 in cycle M+1; `start_ready` = 1 in cycle M+2.
- Empty or illegal operation started at edge N: `done` in cycle N+1.
- Back-to-back start-to-start spacing is `nbeats + 2` cycles.
- All outputs are registered or decoded directly from state; there is no combinational path from `beat_ready` to any output.

## Test plan
- `avl` = 10, `sew` = 0, ready held high → 2 beats. `beat_be` = 0xFF then 0x03; `beat_elem` = 0, 8; `beat_last` on beat 1; `done` 1 cycle later, `err` = 0.
- `avl` = 3, `sew` = 2 → 12 bytes, 2 beats. `beat_be` = 0xFF, 0x0F; `beat_elem` = 0, 2.
- `avl` = 2048, `sew` = 3 → 2048 full beats (all `beat_be` = 0xFF); last `beat_elem` = 2047, `beat_idx` = 2047; single `done`.
- `avl` = 0 → no `beat_valid`; `done` = 1, `err` = 0 one cycle after the start. With `ENABLE_64_BIT` = 0 and `sew` = 3 → `done` = 1, `err` = 1, no beats.
- `avl` = 20, `sew` = 1, `beat_ready` toggled randomly → 5 beats, outputs stable while stalled, `beat_be` of beat 4 = 0xFF, `done` after the last transfer only.
- Abort asserted with `beat_ready` = 1 on beat 1 of 4 → beat 1 not counted, IDLE next cycle, no `done`. The next start with `avl` = 8, `sew` = 0 gives 1 beat, `beat_be` = 0xFF.

Source files
------------

// File: rtl/vec_beat_seq_if.sv
// rtl/vec_beat_seq_if.sv - beat stream between the sequencer and the lane datapath
interface vec_beat_seq_if #(
  parameter int IDX_W  = 15,
  parameter int ELEM_W = 12,
  parameter int BE_W   = 8
);
  logic              beat_valid;
  logic              beat_ready;
  logic [IDX_W-1:0]  beat_idx;
  logic [BE_W-1:0]   beat_be;
  logic [ELEM_W-1:0] beat_elem;
  logic              beat_last;

  modport master (
    output beat_valid, beat_idx, beat_be, beat_elem, beat_last,
    input  beat_ready
  );

  modport slave (
    input  beat_valid, beat_idx, beat_be, beat_elem, beat_last,
    output beat_ready
  );
endinterface

// File: rtl/vec_beat_seq.sv
// rtl/vec_beat_seq.sv - vector beat sequencer
// Turns one (avl, sew) operation into a stream of byte-masked beats and a done pulse.
module vec_beat_seq #(
  parameter int VLEN          = 16384,
  parameter int DATA_WIDTH    = 64,
  parameter int VLMAX         = VLEN >> 3,
  parameter int VLEN_B_BITS   = $clog2(VLMAX),
  parameter bit ENABLE_64_BIT = 1'b1,
  localparam int BPB          = DATA_WIDTH / 8,
  localparam int BB           = $clog2(BPB)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 start_ready,
  input  logic [VLEN_B_BITS:0] avl,
  input  logic [1:0]           sew,
  input  logic                 abort,
  vec_beat_seq_if.master       beat,
  output logic                 done,
  output logic                 err
);

  localparam int NB_W   = VLEN_B_BITS + 4;
  localparam int ELEM_W = VLEN_B_BITS + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sew_q, sew_d;
  logic [BB-1:0]   rem_q, rem_d;
  logic [NB_W-1:0] last_idx_q, last_idx_d;
  logic [NB_W-1:0] beat_idx_q, beat_idx_d;
  logic            err_q, err_d;

  logic [NB_W-1:0] nbytes_in;
  logic [NB_W:0]   nbeats_in;
  logic            illegal_sew;
  logic            is_last;
  logic [4:0]      elem_shamt;
  logic [BPB-1:0]  rem_mask;

  // Byte count is formed at full width so avl = VLMAX with sew = 3 never truncates.
  always_comb begin
    nbytes_in   = {3'b000, avl} << sew;
    nbeats_in   = ({1'b0, nbytes_in} + (NB_W+1)'(BPB - 1)) >> BB;
    illegal_sew = (ENABLE_64_BIT == 1'b0) && (sew == 2'd3);
    is_last     = (beat_idx_q == last_idx_q);
    elem_shamt  = 5'(BB) - {3'b000, sew_q};
  end

  always_comb begin
    for (int b = 0; b < BPB; b++) begin
      rem_mask[b] = (rem_q == '0) || (BB'(b) < rem_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sew_q      <= 2'd0;
      rem_q      <= '0;
      last_idx_q <= '0;
      beat_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sew_q      <= sew_d;
      rem_q      <= rem_d;
      last_idx_q <= last_idx_d;
      beat_idx_q <= beat_idx_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sew_d      = sew_q;
    rem_d      = rem_q;
    last_idx_d = last_idx_q;
    beat_idx_d = beat_idx_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sew_d      = sew;
          rem_d      = nbytes_in[BB-1:0];
          last_idx_d = NB_W'(nbeats_in - (NB_W+1)'(1));
          beat_idx_d = '0;
          err_d      = illegal_sew;
          state_d    = ((avl == '0) || illegal_sew) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        // Abort wins over a beat accepted in the same cycle; that beat is not counted.
        if (abort) begin
          state_d = S_IDLE;
        end else if (beat.beat_ready) begin
          beat_idx_d = beat_idx_q + NB_W'(1);
          if (is_last) begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    start_ready     = (state_q == S_IDLE);
    done            = (state_q == S_FIN);
    err             = (state_q == S_FIN) && err_q;
    beat.beat_valid = (state_q == S_RUN);
    beat.beat_idx   = beat_idx_q;
    beat.beat_last  = (state_q == S_RUN) && is_last;
    beat.beat_elem  = '0;
    beat.beat_be    = '0;
    if (state_q == S_RUN) begin
      beat.beat_elem = ELEM_W'(beat_idx_q << elem_shamt);
      beat.beat_be   = is_last ? rem_mask : {BPB{1'b1}};
    end
  end

endmodule

// File: tb/tb_vec_beat_seq.sv
// tb/tb_vec_beat_seq.sv - directed bench for vec_beat_seq
module tb_vec_beat_seq;

  localparam int VLEN_B_BITS = 11;
  localparam int IDX_W       = VLEN_B_BITS + 4;
  localparam int ELEM_W      = VLEN_B_BITS + 1;
  localparam int BPB         = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start, start_ready, abort, done, err;
  logic [VLEN_B_BITS:0] avl;
  logic [1:0]           sew;
  logic                 start2, start_ready2, abort2, done2, err2;
  logic [VLEN_B_BITS:0] avl2;
  logic [1:0]           sew2;

  int n_tests = 0;
  int n_fail  = 0;

  vec_beat_seq_if #(.IDX_W(IDX_W), .ELEM_W(ELEM_W), .BE_W(BPB)) bif ();
  vec_beat_seq_if #(.IDX_W(IDX_W), .ELEM_W(ELEM_W), .BE_W(BPB)) bif2 ();

  vec_beat_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
    .avl(avl), .sew(sew), .abort(abort), .beat(bif.master),
    .done(done), .err(err)
  );

  vec_beat_seq #(.ENABLE_64_BIT(1'b0)) dut_no64 (
    .clk(clk), .rst_n(rst_n), .start(start2), .start_ready(start_ready2),
    .avl(avl2), .sew(sew2), .abort(abort2), .beat(bif2.master),
    .done(done2), .err(err2)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input string tag, input int a, input int s);
    start = 1'b1;
    avl   = (VLEN_B_BITS+1)'(a);
    sew   = 2'(s);
    chk({tag, ".start_ready"}, start_ready, 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input int idx, input int be, input int elem, input int last);
    chk({tag, ".valid"}, bif.beat_valid, 1);
    chk({tag, ".idx"},   bif.beat_idx, 64'(idx));
    chk({tag, ".be"},    bif.beat_be, 64'(be));
    chk({tag, ".elem"},  bif.beat_elem, 64'(elem));
    chk({tag, ".last"},  bif.beat_last, 64'(last));
    chk({tag, ".nodone"}, done, 0);
    @(negedge clk);
  endtask

  task automatic expect_done(input string tag, input int e);
    chk({tag, ".done"},  done, 1);
    chk({tag, ".err"},   err, 64'(e));
    chk({tag, ".valid"}, bif.beat_valid, 0);
    @(negedge clk);
    chk({tag, ".done_once"}, done, 0);
    chk({tag, ".ready_back"}, start_ready, 1);
  endtask

  initial begin
    int bad;
    int exp_idx;
    logic r;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; avl = '0; sew = '0;
    start2 = 1'b0; abort2 = 1'b0; avl2 = '0; sew2 = '0;
    bif.beat_ready = 1'b1; bif2.beat_ready = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst.start_ready", start_ready, 1);
    chk("rst.valid", bif.beat_valid, 0);
    chk("rst.idx",   bif.beat_idx, 0);
    chk("rst.elem",  bif.beat_elem, 0);
    chk("rst.be",    bif.beat_be, 0);
    chk("rst.last",  bif.beat_last, 0);
    chk("rst.done",  done, 0);
    chk("rst.err",   err, 0);
    chk("rst.done2", done2, 0);
    rst_n = 1'b1;

    // avl=10 sew=0: 10 bytes -> 2 beats, tail mask 0x03
    start_op("t1", 10, 0);
    expect_beat("t1.b0", 0, 8'hFF, 0, 0);
    expect_beat("t1.b1", 1, 8'h03, 8, 1);
    expect_done("t1", 0);

    // avl=3 sew=2: 12 bytes -> 2 beats, tail mask 0x0F
    start_op("t2", 3, 2);
    expect_beat("t2.b0", 0, 8'hFF, 0, 0);
    expect_beat("t2.b1", 1, 8'h0F, 2, 1);
    expect_done("t2", 0);

    // avl=2048 sew=3: 2048 full beats
    start_op("t3", 2048, 3);
    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      if (bif.beat_valid !== 1'b1 || bif.beat_be !== 8'hFF || bif.beat_idx !== IDX_W'(i) ||
          bif.beat_elem !== ELEM_W'(i) || bif.beat_last !== (i == 2047) || done !== 1'b0)
        bad++;
      if (i == 2047) begin
        chk("t3.last_idx",  bif.beat_idx, 2047);
        chk("t3.last_elem", bif.beat_elem, 2047);
        chk("t3.last_flag", bif.beat_last, 1);
      end
      @(negedge clk);
    end
    chk("t3.bad_beats", bad, 0);
    expect_done("t3", 0);

    // avl=0: no beats, done one cycle after the start
    start_op("t4", 0, 0);
    chk("t4.novalid", bif.beat_valid, 0);
    expect_done("t4", 0);

    // sew=3 without 64-bit support: done with err, no beats
    start2 = 1'b1; avl2 = 12'd5; sew2 = 2'd3;
    @(negedge clk);
    start2 = 1'b0;
    chk("t4b.valid", bif2.beat_valid, 0);
    chk("t4b.done",  done2, 1);
    chk("t4b.err",   err2, 1);
    @(negedge clk);
    chk("t4b.done_once", done2, 0);
    chk("t4b.valid2", bif2.beat_valid, 0);

    // avl=20 sew=1: 40 bytes -> 5 full beats under random stalls
    start_op("t5", 20, 1);
    exp_idx = 0;
    for (int c = 0; c < 300 && exp_idx < 5; c++) begin
      chk("t5.valid", bif.beat_valid, 1);
      chk("t5.idx",   bif.beat_idx, 64'(exp_idx));
      chk("t5.be",    bif.beat_be, 8'hFF);
      chk("t5.elem",  bif.beat_elem, 64'(exp_idx * 4));
      chk("t5.last",  bif.beat_last, 64'(exp_idx == 4));
      chk("t5.nodone", done, 0);
      r = (c >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
      bif.beat_ready = r;
      @(negedge clk);
      if (r) exp_idx++;
    end
    chk("t5.all_beats", exp_idx, 5);
    bif.beat_ready = 1'b1;
    expect_done("t5", 0);

    // abort on beat 1 of 4 with ready high
    start_op("t6", 32, 0);
    expect_beat("t6.b0", 0, 8'hFF, 0, 0);
    chk("t6.idx1", bif.beat_idx, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t6.valid", bif.beat_valid, 0);
    chk("t6.nodone", done, 0);
    chk("t6.idle", start_ready, 1);
    chk("t6.not_counted", bif.beat_idx, 1);
    @(negedge clk);
    chk("t6.nodone2", done, 0);
    start_op("t6n", 8, 0);
    expect_beat("t6n.b0", 0, 8'hFF, 0, 1);
    expect_done("t6n", 0);

    // reset in the middle of an operation drops it without done
    start_op("t7", 32, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t7.valid", bif.beat_valid, 0);
    chk("t7.done",  done, 0);
    chk("t7.idx",   bif.beat_idx, 0);
    chk("t7.ready", start_ready, 1);
    @(negedge clk);
    chk("t7.done2", done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
